// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: round-robin share of one AXI4-Lite slave between NM masters, one transaction at a time
module axi4_lite_arbiter #(
    parameter int NM     = 2,
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic                     i_aClk,
    input  logic                     i_aResetn,
    input  logic [NM-1:0]            i_m_arValid,
    output logic [NM-1:0]            o_m_arReady,
    input  logic [NM*AWIDTH-1:0]     i_m_arAddr,
    input  logic [NM*3-1:0]          i_m_arProt,
    output logic [NM-1:0]            o_m_rValid,
    input  logic [NM-1:0]            i_m_rReady,
    output logic [NM*DWIDTH-1:0]     o_m_rData,
    output logic [NM*2-1:0]          o_m_rResp,
    input  logic [NM-1:0]            i_m_awValid,
    output logic [NM-1:0]            o_m_awReady,
    input  logic [NM*AWIDTH-1:0]     i_m_awAddr,
    input  logic [NM*3-1:0]          i_m_awProt,
    input  logic [NM-1:0]            i_m_wValid,
    output logic [NM-1:0]            o_m_wReady,
    input  logic [NM*DWIDTH-1:0]     i_m_wData,
    input  logic [NM*DWIDTH/8-1:0]   i_m_wStrb,
    output logic [NM-1:0]            o_m_bValid,
    input  logic [NM-1:0]            i_m_bReady,
    output logic [NM*2-1:0]          o_m_bResp,
    output logic                     o_s_arValid,
    input  logic                     i_s_arReady,
    output logic [AWIDTH-1:0]        o_s_arAddr,
    output logic [2:0]               o_s_arProt,
    input  logic                     i_s_rValid,
    output logic                     o_s_rReady,
    input  logic [DWIDTH-1:0]        i_s_rData,
    input  logic [1:0]               i_s_rResp,
    output logic                     o_s_awValid,
    input  logic                     i_s_awReady,
    output logic [AWIDTH-1:0]        o_s_awAddr,
    output logic [2:0]               o_s_awProt,
    output logic                     o_s_wValid,
    input  logic                     i_s_wReady,
    output logic [DWIDTH-1:0]        o_s_wData,
    output logic [DWIDTH/8-1:0]      o_s_wStrb,
    input  logic                     i_s_bValid,
    output logic                     o_s_bReady,
    input  logic [1:0]               i_s_bResp,
    output logic [NM-1:0]            o_grant,
    output logic                     o_grantWrite
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DWIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_RESP} state_t;

    state_t          r_state, w_next;
    logic [NM-1:0]   r_grant, r_rw_toggle;
    logic [IW-1:0]   r_gidx, r_rr_ptr, w_sel;
    logic [IW:0]     w_idx;
    logic            r_write, r_aw_done, r_w_done;
    logic [NM-1:0]   w_rd_req, w_wr_req, w_req;
    logic            w_found, w_sel_write, w_aw_hs, w_w_hs;
    logic            w_rd_addr, w_rd_data, w_wr_addr, w_wr_resp;

    assign w_rd_req  = i_m_arValid;
    assign w_wr_req  = i_m_awValid | i_m_wValid;
    assign w_req     = w_rd_req | w_wr_req;
    assign w_rd_addr = r_state == S_RD_ADDR;
    assign w_rd_data = r_state == S_RD_DATA;
    assign w_wr_addr = r_state == S_WR_ADDR;
    assign w_wr_resp = r_state == S_WR_RESP;

    // first requester at or after the round-robin pointer, wrapping modulo NM
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NM; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NM)) w_idx = w_idx - (IW+1)'(NM);
            if (!w_found && w_req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[IW-1:0];
            end
        end
    end

    // a master asking for both kinds alternates, starting with the write
    assign w_sel_write = w_wr_req[w_sel] & (~w_rd_req[w_sel] | ~r_rw_toggle[w_sel]);

    assign o_s_arValid = w_rd_addr & i_m_arValid[r_gidx];
    assign o_s_arAddr  = i_m_arAddr[int'(r_gidx)*AWIDTH +: AWIDTH];
    assign o_s_arProt  = i_m_arProt[int'(r_gidx)*3 +: 3];
    assign o_s_rReady  = w_rd_data & i_m_rReady[r_gidx];
    assign o_s_awValid = w_wr_addr & ~r_aw_done & i_m_awValid[r_gidx];
    assign o_s_awAddr  = i_m_awAddr[int'(r_gidx)*AWIDTH +: AWIDTH];
    assign o_s_awProt  = i_m_awProt[int'(r_gidx)*3 +: 3];
    assign o_s_wValid  = w_wr_addr & ~r_w_done & i_m_wValid[r_gidx];
    assign o_s_wData   = i_m_wData[int'(r_gidx)*DWIDTH +: DWIDTH];
    assign o_s_wStrb   = i_m_wStrb[int'(r_gidx)*SW +: SW];
    assign o_s_bReady  = w_wr_resp & i_m_bReady[r_gidx];

    assign w_aw_hs = o_s_awValid & i_s_awReady;
    assign w_w_hs  = o_s_wValid & i_s_wReady;

    assign o_m_arReady  = r_grant & {NM{w_rd_addr & i_s_arReady}};
    assign o_m_rValid   = r_grant & {NM{w_rd_data & i_s_rValid}};
    assign o_m_awReady  = r_grant & {NM{w_wr_addr & ~r_aw_done & i_s_awReady}};
    assign o_m_wReady   = r_grant & {NM{w_wr_addr & ~r_w_done & i_s_wReady}};
    assign o_m_bValid   = r_grant & {NM{w_wr_resp & i_s_bValid}};
    assign o_grant      = r_grant;
    assign o_grantWrite = r_write;

    for (genvar n = 0; n < NM; n++) begin : g_resp
        assign o_m_rData[n*DWIDTH +: DWIDTH] = r_grant[n] ? i_s_rData : '0;
        assign o_m_rResp[n*2 +: 2]           = r_grant[n] ? i_s_rResp : '0;
        assign o_m_bResp[n*2 +: 2]           = r_grant[n] ? i_s_bResp : '0;
    end

    // state register
    always_ff @(posedge i_aClk or negedge i_aResetn)
        if (!i_aResetn) r_state <= S_IDLE;
        else            r_state <= w_next;

    // transaction sequencing; every completion passes through IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = w_sel_write ? S_WR_ADDR : S_RD_ADDR;
            S_RD_ADDR: if (o_s_arValid && i_s_arReady) w_next = S_RD_DATA;
            S_RD_DATA: if (i_s_rValid && o_s_rReady) w_next = S_IDLE;
            S_WR_ADDR: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WR_RESP;
            S_WR_RESP: if (i_s_bValid && o_s_bReady) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // grant, round-robin pointer, read/write alternation and write-channel done flags
    always_ff @(posedge i_aClk or negedge i_aResetn)
        if (!i_aResetn) begin
            r_grant     <= '0;
            r_gidx      <= '0;
            r_write     <= 1'b0;
            r_rr_ptr    <= '0;
            r_rw_toggle <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant  <= {{(NM-1){1'b0}}, 1'b1} << w_sel;
                r_gidx   <= w_sel;
                r_write  <= w_sel_write;
                r_rr_ptr <= (int'(w_sel) == NM-1) ? '0 : w_sel + 1'b1;
                if (w_rd_req[w_sel] && w_wr_req[w_sel]) r_rw_toggle[w_sel] <= ~r_rw_toggle[w_sel];
            end else if (w_next == S_IDLE) begin
                r_grant <= '0;
                r_write <= 1'b0;
            end
            if (w_wr_addr && w_next == S_WR_ADDR) begin
                r_aw_done <= r_aw_done | w_aw_hs;
                r_w_done  <= r_w_done | w_w_hs;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb_axi4_lite_arbiter: directed checks of arbitration order, pass-through and reset behaviour
module tb_axi4_lite_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_arValid, m_arReady, m_rValid, m_rReady, m_awValid, m_awReady;
    logic [1:0]  m_wValid, m_wReady, m_bValid, m_bReady;
    logic [23:0] m_arAddr, m_awAddr;
    logic [5:0]  m_arProt, m_awProt;
    logic [63:0] m_rData, m_wData;
    logic [3:0]  m_rResp, m_bResp;
    logic [7:0]  m_wStrb;
    logic        s_arValid, s_arReady, s_rValid, s_rReady, s_awValid, s_awReady;
    logic        s_wValid, s_wReady, s_bValid, s_bReady;
    logic [11:0] s_arAddr, s_awAddr;
    logic [2:0]  s_arProt, s_awProt;
    logic [31:0] s_rData, s_wData;
    logic [3:0]  s_wStrb;
    logic [1:0]  s_rResp, s_bResp, grant;
    logic        grant_write;
    int          n_tests = 0;
    int          n_fail = 0;

    axi4_lite_arbiter #(.NM(2), .AWIDTH(12), .DWIDTH(32)) dut (
        .i_aClk(clk), .i_aResetn(rst_n),
        .i_m_arValid(m_arValid), .o_m_arReady(m_arReady), .i_m_arAddr(m_arAddr), .i_m_arProt(m_arProt),
        .o_m_rValid(m_rValid), .i_m_rReady(m_rReady), .o_m_rData(m_rData), .o_m_rResp(m_rResp),
        .i_m_awValid(m_awValid), .o_m_awReady(m_awReady), .i_m_awAddr(m_awAddr), .i_m_awProt(m_awProt),
        .i_m_wValid(m_wValid), .o_m_wReady(m_wReady), .i_m_wData(m_wData), .i_m_wStrb(m_wStrb),
        .o_m_bValid(m_bValid), .i_m_bReady(m_bReady), .o_m_bResp(m_bResp),
        .o_s_arValid(s_arValid), .i_s_arReady(s_arReady), .o_s_arAddr(s_arAddr), .o_s_arProt(s_arProt),
        .i_s_rValid(s_rValid), .o_s_rReady(s_rReady), .i_s_rData(s_rData), .i_s_rResp(s_rResp),
        .o_s_awValid(s_awValid), .i_s_awReady(s_awReady), .o_s_awAddr(s_awAddr), .o_s_awProt(s_awProt),
        .o_s_wValid(s_wValid), .i_s_wReady(s_wReady), .o_s_wData(s_wData), .o_s_wStrb(s_wStrb),
        .i_s_bValid(s_bValid), .o_s_bReady(s_bReady), .i_s_bResp(s_bResp),
        .o_grant(grant), .o_grantWrite(grant_write)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_arValid = '0; m_awValid = '0; m_wValid = '0; m_rReady = 2'b11; m_bReady = 2'b11;
        m_arAddr = '0; m_awAddr = '0; m_arProt = '0; m_awProt = '0; m_wData = '0; m_wStrb = '0;
        s_arReady = 1'b0; s_rValid = 1'b0; s_awReady = 1'b0; s_wReady = 1'b0; s_bValid = 1'b0;
        s_rData = '0; s_rResp = '0; s_bResp = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // called in the cycle right after the grant edge of a read
    task automatic rd_txn(input logic [1:0] g, input logic [11:0] addr, input logic [31:0] data);
        check("rd_grant", grant, g);
        check("rd_kind", grant_write, 0);
        check("rd_s_arValid", s_arValid, 1);
        check("rd_s_arAddr", s_arAddr, addr);
        s_arReady = 1'b1;
        #1;
        check("rd_m_arReady", m_arReady, g);
        tick();
        s_arReady = 1'b0;
        m_arValid &= ~g;
        s_rValid = 1'b1;
        s_rData = data;
        #1;
        check("rd_s_arValid_off", s_arValid, 0);
        check("rd_m_rValid", m_rValid, g);
        check("rd_m_rData", m_rData, {g[1] ? data : 32'h0, g[0] ? data : 32'h0});
        tick();
        s_rValid = 1'b0;
        check("rd_idle_grant", grant, 0);
    endtask

    // called in the cycle right after the grant edge of a write
    task automatic wr_txn(input logic [1:0] g, input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        check("wr_grant", grant, g);
        check("wr_kind", grant_write, 1);
        check("wr_s_awValid", s_awValid, 1);
        check("wr_s_wValid", s_wValid, 1);
        check("wr_s_awAddr", s_awAddr, addr);
        check("wr_s_wData", s_wData, data);
        check("wr_s_wStrb", s_wStrb, strb);
        s_awReady = 1'b1;
        s_wReady = 1'b1;
        #1;
        check("wr_m_awReady", m_awReady, g);
        check("wr_m_wReady", m_wReady, g);
        tick();
        s_awReady = 1'b0;
        s_wReady = 1'b0;
        m_awValid &= ~g;
        m_wValid &= ~g;
        s_bValid = 1'b1;
        s_bResp = 2'b00;
        #1;
        check("wr_m_bValid", m_bValid, g);
        check("wr_m_bResp", m_bResp, 0);
        tick();
        s_bValid = 1'b0;
        check("wr_idle_grant", grant, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        m_arValid = 2'b11; m_awValid = 2'b11; m_wValid = 2'b11;
        s_arReady = 1'b1; s_awReady = 1'b1; s_wReady = 1'b1; s_rValid = 1'b1; s_bValid = 1'b1;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_grantWrite", grant_write, 0);
        check("rst_s_valids", {s_arValid, s_awValid, s_wValid}, 0);
        check("rst_s_readies", {s_rReady, s_bReady}, 0);
        check("rst_m_readies", {m_arReady, m_awReady, m_wReady}, 0);
        check("rst_m_valids", {m_rValid, m_bValid}, 0);
        clear_inputs();
        rst_n = 1'b1;
        tick();

        m_awValid = 2'b01; m_wValid = 2'b01;
        m_awAddr = {12'hABC, 12'h004}; m_wData = {32'h12345678, 32'hDEADBEEF}; m_wStrb = 8'h3F;
        tick();
        wr_txn(2'b01, 12'h004, 32'hDEADBEEF, 4'hF);

        do_reset();
        m_arValid = 2'b11; m_arAddr = {12'h200, 12'h100};
        tick();
        rd_txn(2'b01, 12'h100, 32'h11111111);
        tick();
        rd_txn(2'b10, 12'h200, 32'h22222222);
        m_arValid = 2'b11; m_arAddr = {12'h220, 12'h110};
        tick();
        rd_txn(2'b01, 12'h110, 32'h33333333);
        tick();
        rd_txn(2'b10, 12'h220, 32'h44444444);

        do_reset();
        m_arValid = 2'b10; m_arAddr = {12'h300, 12'h000};
        m_awValid = 2'b10; m_wValid = 2'b10; m_awAddr = {12'h304, 12'h000};
        m_wData = {32'hA1A1A1A1, 32'h0}; m_wStrb = 8'hC0;
        tick();
        wr_txn(2'b10, 12'h304, 32'hA1A1A1A1, 4'hC);
        m_awValid = 2'b10; m_wValid = 2'b10; m_awAddr = {12'h308, 12'h000};
        m_wData = {32'hA2A2A2A2, 32'h0}; m_wStrb = 8'h30;
        tick();
        rd_txn(2'b10, 12'h300, 32'hB1B1B1B1);
        m_arValid = 2'b10; m_arAddr = {12'h30C, 12'h000};
        tick();
        wr_txn(2'b10, 12'h308, 32'hA2A2A2A2, 4'h3);
        tick();
        rd_txn(2'b10, 12'h30C, 32'hB2B2B2B2);

        m_awValid = 2'b01; m_wValid = 2'b01;
        m_awAddr = {12'h000, 12'h010}; m_wData = {32'h0, 32'hCAFEF00D}; m_wStrb = 8'h03;
        tick();
        check("split_grant", grant, 2'b01);
        check("split_kind", grant_write, 1);
        s_awReady = 1'b1;
        s_bValid = 1'b1;
        #1;
        check("split_m_awReady", m_awReady, 2'b01);
        check("split_m_wReady_early", m_wReady, 2'b00);
        tick();
        s_awReady = 1'b0;
        m_awValid = 2'b00;
        #1;
        check("split_s_awValid_off", s_awValid, 0);
        check("split_s_wValid_on", s_wValid, 1);
        check("split_no_b_1", m_bValid, 2'b00);
        tick();
        check("split_no_b_2", m_bValid, 2'b00);
        tick();
        s_wReady = 1'b1;
        #1;
        check("split_m_wReady", m_wReady, 2'b01);
        check("split_no_b_3", m_bValid, 2'b00);
        tick();
        s_wReady = 1'b0;
        m_wValid = 2'b00;
        #1;
        check("split_b", m_bValid, 2'b01);
        tick();
        check("split_b_once", m_bValid, 2'b00);
        check("split_idle", grant, 2'b00);
        s_bValid = 1'b0;
        tick();
        check("split_stay_idle", grant, 2'b00);

        m_arValid = 2'b01; m_arAddr = {12'h000, 12'h020};
        tick();
        check("rstmid_grant", grant, 2'b01);
        s_arReady = 1'b1;
        tick();
        s_arReady = 1'b0;
        m_arValid = 2'b00;
        m_rReady = 2'b00;
        s_rValid = 1'b1;
        s_rData = 32'h0BADF00D;
        #1;
        check("rstmid_rValid", m_rValid, 2'b01);
        rst_n = 1'b0;
        tick();
        check("rstmid_grant_off", grant, 2'b00);
        check("rstmid_rValid_off", m_rValid, 2'b00);
        rst_n = 1'b1;
        s_rValid = 1'b0;
        m_rReady = 2'b11;
        tick();
        m_arValid = 2'b01; m_arAddr = {12'h000, 12'h024};
        tick();
        rd_txn(2'b01, 12'h024, 32'h5A5A5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
